// File: rtl/imem_loader.sv
// Writable 64-word instruction memory filled from a framed byte stream; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [5:0]   addr,
    output logic [N-1:0] q,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err,
    output logic [6:0]   words_loaded
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WORD = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic          rx_ready_r;
    logic          cpu_hold_r;
    logic          load_done_r;
    logic          load_err_r;
    logic [6:0]    words_loaded_r;
    logic [6:0]    count_r;
    logic [6:0]    ptr_r;
    logic [1:0]    byte_idx_r;
    logic [23:0]   word_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif
    logic [N-1:0]  mem_r [0:DEPTH-1];

    logic          accept_s;
    logic          wr_en_s;
    logic          last_word_s;
    logic [N-1:0]  wr_data_s;

    function automatic logic header_ok(input logic [7:0] b);
        return (b[7:6] == 2'b10);
    endfunction

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Handshake decode and write strobe for the byte that completes a word
    always_comb begin
        accept_s    = 1'b0;
        wr_en_s     = 1'b0;
        wr_data_s   = {rx_data, word_r};
        last_word_s = ((ptr_r + 7'd1) == count_r);
        if (rx_valid && rx_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (accept_s && (state_r == ST_WORD) && (byte_idx_r == 2'd3)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Instruction storage: never reset so an image survives a CPU reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ptr_r[5:0]] <= wr_data_s;
        end
    end

    assign q = mem_r[addr];

    // Loader FSM with registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            rx_ready_r     <= 1'b1;
            cpu_hold_r     <= 1'b1;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
            words_loaded_r <= 7'd0;
            count_r        <= 7'd0;
            ptr_r          <= 7'd0;
            byte_idx_r     <= 2'd0;
            word_r         <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r         <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (header_ok(rx_data)) begin
                            count_r        <= {1'b0, rx_data[5:0]} + 7'd1;
                            load_err_r     <= 1'b0;
                            words_loaded_r <= 7'd0;
                            ptr_r          <= 7'd0;
                            byte_idx_r     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_r         <= 8'd0;
`endif
                            state_r        <= ST_WORD;
                        end else begin
                            load_err_r <= 1'b1;
                        end
                    end
                end
                ST_WORD: begin
                    if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r <= csum_next(csum_r, rx_data);
`endif
                        case (byte_idx_r)
                            2'd0: begin
                                word_r[7:0] <= rx_data;
                                byte_idx_r  <= 2'd1;
                            end
                            2'd1: begin
                                word_r[15:8] <= rx_data;
                                byte_idx_r   <= 2'd2;
                            end
                            2'd2: begin
                                word_r[23:16] <= rx_data;
                                byte_idx_r    <= 2'd3;
                            end
                            default: begin
                                byte_idx_r     <= 2'd0;
                                ptr_r          <= ptr_r + 7'd1;
                                words_loaded_r <= words_loaded_r + 7'd1;
                                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_r     <= ST_CSUM;
`else
                                    state_r     <= ST_DONE;
                                    rx_ready_r  <= 1'b0;
                                    cpu_hold_r  <= 1'b0;
                                    load_done_r <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept_s) begin
                        if (rx_data == csum_r) begin
                            state_r     <= ST_DONE;
                            rx_ready_r  <= 1'b0;
                            cpu_hold_r  <= 1'b0;
                            load_done_r <= 1'b1;
                        end else begin
                            load_err_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    // Terminal until reset; outputs already reflect completion
                    rx_ready_r  <= 1'b0;
                    cpu_hold_r  <= 1'b0;
                    load_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rx_ready_r  <= 1'b1;
                    cpu_hold_r  <= 1'b1;
                    load_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_r;
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: each issued byte queues its expected post-accept status.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [5:0]  addr = 6'd0;
    logic [31:0] q;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [6:0]  words_loaded;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [6:0] wl;
        logic       done;
        logic       err;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    imem_loader #(.N(32), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .addr         (addr),
        .q            (q),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted byte pops one expectation and compares status 1 ns after the edge
    always @(posedge clk) begin
        if (reset && rx_valid && rx_ready) begin
            #1;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_accept got a transfer with no expectation queued at %0t", $time);
            end else begin
                mon_e = expq.pop_front();
                if ({words_loaded, load_done, load_err, cpu_hold, rx_ready} !==
                    {mon_e.wl, mon_e.done, mon_e.err, ~mon_e.done, ~mon_e.done}) begin
                    errors++;
                    $display("FAIL accept_status got wl=%0d done=%b err=%b hold=%b ready=%b, want wl=%0d done=%b err=%b hold=%b ready=%b at %0t",
                             words_loaded, load_done, load_err, cpu_hold, rx_ready,
                             mon_e.wl, mon_e.done, mon_e.err, ~mon_e.done, ~mon_e.done, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with rx_valid still high
    task automatic send(input logic [7:0] b, input logic [6:0] wl, input logic done,
                        input logic err, input bit gap);
        int n;
        exp_t e;
        if (gap) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        e.wl = wl; e.done = done; e.err = err;
        expq.push_back(e);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            if (rx_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte %h never accepted", b);
                void'(expq.pop_back());
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [6:0] wl_before,
                             input logic last_done, input bit gap);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) send(w[8*k +: 8], wl_before + 7'd1, last_done, 1'b0, gap);
            else        send(w[8*k +: 8], wl_before, 1'b0, 1'b0, gap);
        end
    endtask

    task automatic stop();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic  csum_en;
    time   t0;
    time   t1;

    initial begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_en = 1'b1;
`else
        csum_en = 1'b0;
`endif
        // Asynchronous reset asserted mid-cycle takes effect immediately
        #23 reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
        chk("rst_done",  {31'd0, load_done}, 32'd0);
        chk("rst_err",   {31'd0, load_err}, 32'd0);
        chk("rst_words", {25'd0, words_loaded}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single-word load
        send(8'h80, 7'd0, 1'b0, 1'b0, 1'b0);
        send_word(32'h8b1f03e9, 7'd0, ~csum_en, 1'b0);
        if (csum_en) send(8'h7e, 7'd1, 1'b1, 1'b0, 1'b0);
        stop();
        addr = 6'd0;
        #1 chk("single_q0", q, 32'h8b1f03e9);
        // DONE refuses further bytes
        @(negedge clk);
        rx_data = 8'h80; rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        stop();
        chk("done_words", {25'd0, words_loaded}, 32'd1);
        chk("done_ready", {31'd0, rx_ready}, 32'd0);

        // Full 64-word back-to-back load
        pulse_reset();
        t0 = $time;
        send(8'hBF, 7'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            send_word(32'h1000_0000 + i, 7'(i), (i == 63) && !csum_en, 1'b0);
        end
        if (csum_en) send(8'h00, 7'd64, 1'b1, 1'b0, 1'b0);
        t1 = $time;
        stop();
        chk("full_cycles", 32'((t1 - t0) / 10), csum_en ? 32'd258 : 32'd257);
        chk("full_words", {25'd0, words_loaded}, 32'd64);
        addr = 6'd63;
        #1 chk("full_q63", q, 32'h1000_003f);
        addr = 6'd0;
        #1 chk("full_q0", q, 32'h1000_0000);

        // Bad header then a good load
        pulse_reset();
        send(8'h05, 7'd0, 1'b0, 1'b1, 1'b0);
        send(8'h80, 7'd0, 1'b0, 1'b0, 1'b0);
        send_word(32'hdeadbeef, 7'd0, ~csum_en, 1'b0);
        if (csum_en) send(8'h22, 7'd1, 1'b1, 1'b0, 1'b0);
        stop();
        addr = 6'd0;
        #1 chk("badhdr_q0", q, 32'hdeadbeef);
        addr = 6'd1;
        #1 chk("badhdr_q1_kept", q, 32'h1000_0001);

        // Reset after two of three words
        pulse_reset();
        send(8'h82, 7'd0, 1'b0, 1'b0, 1'b0);
        send_word(32'h11223344, 7'd0, 1'b0, 1'b0);
        send_word(32'h55667788, 7'd1, 1'b0, 1'b0);
        stop();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_words", {25'd0, words_loaded}, 32'd0);
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        addr = 6'd0;
        #1 chk("midrst_q0", q, 32'h11223344);
        addr = 6'd1;
        #1 chk("midrst_q1", q, 32'h55667788);

        // Same image again with random rx_valid gaps
        @(negedge clk);
        send(8'h82, 7'd0, 1'b0, 1'b0, 1'b1);
        send_word(32'h11223344, 7'd0, 1'b0, 1'b1);
        send_word(32'h55667788, 7'd1, 1'b0, 1'b1);
        send_word(32'h99aabbcc, 7'd2, ~csum_en, 1'b1);
        if (csum_en) send(8'hcc, 7'd3, 1'b1, 1'b0, 1'b1);
        stop();
        addr = 6'd2;
        #1 chk("gap_q2", q, 32'h99aabbcc);
        addr = 6'd0;
        #1 chk("gap_q0", q, 32'h11223344);
        chk("gap_done", {31'd0, load_done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum returns to IDLE with error; a correct reload succeeds
        pulse_reset();
        send(8'h80, 7'd0, 1'b0, 1'b0, 1'b0);
        send_word(32'h8b1f03e9, 7'd0, 1'b0, 1'b0);
        send(8'h00, 7'd1, 1'b0, 1'b1, 1'b0);
        send(8'h80, 7'd0, 1'b0, 1'b0, 1'b1);
        send_word(32'h8b1f03e9, 7'd0, 1'b0, 1'b1);
        send(8'h7e, 7'd1, 1'b1, 1'b0, 1'b1);
        stop();
        addr = 6'd0;
        #1 chk("csum_q0", q, 32'h8b1f03e9);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
